// File: rtl/pwm_decoder_pkg.sv
// Shared types, widths and helpers for the PWM decoder.
package pwm_decoder_pkg;

  localparam int unsigned PWM_PERIOD = 256;
  localparam int unsigned DUTY_W     = $clog2(PWM_PERIOD);
  localparam int unsigned PER_W      = $clog2(2 * PWM_PERIOD);
  localparam int unsigned SPEED_W    = DUTY_W + 1;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2,
    WAIT_FALL = 2'd3
  } state_e;

  // Signed speed from duty and direction; contradictory direction gives zero.
  function automatic logic [SPEED_W-1:0] calc_speed(input logic [DUTY_W-1:0] d,
                                                     input logic dp,
                                                     input logic dn);
    logic [SPEED_W-1:0] mag;
    mag = SPEED_W'({1'b0, d});
    if (dp == dn) return '0;
    else if (dp)  return mag;
    else          return SPEED_W'(0) - mag;
  endfunction

endpackage

// File: rtl/pwm_decoder_sync2.sv
// Two-flop synchronizer for one asynchronous input line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_decoder.sv
// PWM duty/period decoder with direction-signed speed and idle timeout.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pwm_in,
  input  logic               dirp,
  input  logic               dirn,
  output logic               valid,
  output logic [DUTY_W-1:0]  duty,
  output logic [PER_W-1:0]   period,
  output logic [SPEED_W-1:0] speed,
  output logic               timeout,
  output logic               dir_err
);

  logic pwm_s, dirp_s, dirn_s;
  logic pwm_d, rise_q, fall_q;
  logic [1:0] settle;
  logic primed;

  state_e state, state_nx;
  logic [DUTY_W-1:0] hi_cnt, hi_nx, emit_duty;
  logic [PER_W-1:0]  per_cnt, per_nx, idle_cnt, idle_nx, emit_period;
  logic emit, emit_tmo, tmo_hit;

  sync2 u_sync_pwm  (.clk(clk), .rst_n(rst_n), .d(pwm_in), .q(pwm_s));
  sync2 u_sync_dirp (.clk(clk), .rst_n(rst_n), .d(dirp),   .q(dirp_s));
  sync2 u_sync_dirn (.clk(clk), .rst_n(rst_n), .d(dirn),   .q(dirn_s));

  // Edges are ignored until the synchronizer and delay flop hold real line
  // samples, so a line already high at reset release is not seen as a rise.
  assign primed = (settle == 2'd3);

  // Settle counter after reset.
  always_ff @(posedge clk) begin
    if (!rst_n)       settle <= 2'd0;
    else if (!primed) settle <= settle + 2'd1;
  end

  // Registered edge detect on the synchronized line; pwm_d is the aligned level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_d  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      pwm_d  <= pwm_s;
      rise_q <= primed & pwm_s & ~pwm_d;
      fall_q <= primed & ~pwm_s & pwm_d;
    end
  end

  assign tmo_hit = (idle_cnt == PER_W'(TIMEOUT - 1));

  // Next-state, counter and emit decode.
  always_comb begin
    state_nx    = state;
    hi_nx       = hi_cnt;
    per_nx      = per_cnt;
    idle_nx     = idle_cnt;
    emit        = 1'b0;
    emit_tmo    = 1'b0;
    emit_duty   = hi_cnt;
    emit_period = per_cnt;

    if (!en) begin
      state_nx = WAIT_RISE;
      hi_nx    = '0;
      per_nx   = '0;
      idle_nx  = '0;
    end else begin
      idle_nx = (rise_q | fall_q) ? '0 : idle_cnt + PER_W'(1);

      case (state)
        WAIT_RISE: begin
          if (rise_q) begin
            state_nx = HIGH;
            hi_nx    = DUTY_W'(1);
            per_nx   = PER_W'(1);
          end
        end
        HIGH: begin
          per_nx = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
          if (fall_q) state_nx = LOW;
          else        hi_nx = (hi_cnt == '1) ? hi_cnt : hi_cnt + DUTY_W'(1);
        end
        LOW: begin
          if (rise_q) begin
            emit     = 1'b1;
            state_nx = HIGH;
            hi_nx    = DUTY_W'(1);
            per_nx   = PER_W'(1);
          end else begin
            per_nx = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
          end
        end
        WAIT_FALL: begin
          if (fall_q) state_nx = WAIT_RISE;
        end
        default: state_nx = WAIT_RISE;
      endcase

      // Any edge restarts the idle window, so it also wins over a timeout.
      if (tmo_hit && !(rise_q || fall_q)) begin
        emit        = 1'b1;
        emit_tmo    = 1'b1;
        emit_duty   = pwm_d ? '1 : '0;
        emit_period = '0;
        state_nx    = pwm_d ? WAIT_FALL : WAIT_RISE;
        hi_nx       = '0;
        per_nx      = '0;
        idle_nx     = '0;
      end

      if (state_nx != state) idle_nx = '0;
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= WAIT_RISE;
      hi_cnt   <= '0;
      per_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      hi_cnt   <= hi_nx;
      per_cnt  <= per_nx;
      idle_cnt <= idle_nx;
    end
  end

  // Measurement outputs; held between emissions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      duty    <= '0;
      period  <= '0;
      speed   <= '0;
      timeout <= 1'b0;
      dir_err <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) begin
        duty    <= emit_duty;
        period  <= emit_period;
        timeout <= emit_tmo;
        dir_err <= (dirp_s == dirn_s);
        speed   <= calc_speed(emit_duty, dirp_s, dirn_s);
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: stimulus pushes expected measurements,
// a negedge monitor pops and compares whenever valid is seen.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, pwm_in, dirp, dirn;
  logic       valid, timeout, dir_err;
  logic [7:0] duty;
  logic [8:0] period, speed;

  pwm_decoder #(.TIMEOUT(300)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .dirp(dirp), .dirn(dirn), .valid(valid), .duty(duty),
    .period(period), .speed(speed), .timeout(timeout), .dir_err(dir_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int duty;
    int period;
    int speed;
    int tmo;
    int derr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: line history in edge-index time.
  bit cur_dp, cur_dn, have_rise;
  int last_rise, last_h, last_duty;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int model_speed(input int d, input bit dp, input bit dn);
    if (dp == dn) return 0;
    if (dp) return d;
    return (512 - d) % 512;
  endfunction

  task automatic push_exp(input int at, input int d, input int p, input int t);
    exp_t e;
    e.at = at; e.duty = d; e.period = p; e.tmo = t;
    e.speed = model_speed(d, cur_dp, cur_dn);
    e.derr  = (cur_dp == cur_dn) ? 1 : 0;
    last_duty = d;
    sb.push_back(e);
  endtask

  // Raise the line; a rise after a previous rise closes a full period.
  task automatic drive_rise();
    int tr;
    pwm_in = 1'b1;
    tr = cyc + 1;
    if (have_rise) push_exp(tr + 3, sat(last_h, 255), sat(tr - last_rise, 511), 0);
    have_rise = 1'b1;
    last_rise = tr;
  endtask

  // One PWM period: h cycles high, l cycles low; direction changes at the fall.
  task automatic pwm_seg(input int h, input int l, input bit dp, input bit dn);
    drive_rise();
    last_h = h;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    dirp = dp; dirn = dn; cur_dp = dp; cur_dn = dn;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   int'(valid),   0);
    check({tag, "_duty"},    int'(duty),    0);
    check({tag, "_period"},  int'(period),  0);
    check({tag, "_speed"},   int'(speed),   0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_dir_err"}, int'(dir_err), 0);
  endtask

  // Monitor: compare every presented measurement with the oldest expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("emit_cycle", cyc,             mon_e.at);
        check("duty",       int'(duty),      mon_e.duty);
        check("period",     int'(period),    mon_e.period);
        check("speed",      int'(speed),     mon_e.speed);
        check("timeout",    int'(timeout),   mon_e.tmo);
        check("dir_err",    int'(dir_err),   mon_e.derr);
      end
    end
  end

  initial begin
    int n0, tr;
    rst_n = 1'b0; en = 1'b1; pwm_in = 1'b0; dirp = 1'b1; dirn = 1'b0;
    cur_dp = 1'b1; cur_dn = 1'b0; have_rise = 1'b0;
    last_rise = 0; last_h = 0; last_duty = 0;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // Line held low from reset release: timeouts every 300 cycles.
    rst_n = 1'b1;
    n0 = cyc;
    push_exp(n0 + 300, 0, 0, 1);
    push_exp(n0 + 600, 0, 0, 1);
    repeat (700) @(negedge clk);

    // Line held high after a rise: high timeouts, then resume.
    pwm_in = 1'b1;
    tr = cyc + 1;
    push_exp(tr + 303, 255, 0, 1);
    push_exp(tr + 603, 255, 0, 1);
    repeat (700) @(negedge clk);
    pwm_in = 1'b0;
    have_rise = 1'b0;
    repeat (100) @(negedge clk);

    for (int i = 0; i < 5; i++) pwm_seg(64, 192, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pwm_seg(100, 156, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pwm_seg(50, 206, 1'b1, 1'b1);

    // Saturation and short-pulse boundaries.
    pwm_seg(255, 40, 1'b1, 1'b0);
    pwm_seg(299, 299, 1'b1, 1'b0);
    pwm_seg(3, 8, 1'b0, 1'b1);
    pwm_seg(64, 192, 1'b1, 1'b0);
    pwm_seg(64, 192, 1'b1, 1'b0);

    // Disable: no valid, outputs hold, a full period needed afterwards.
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("en_off_valid", int'(valid), 0);
    check("en_off_duty_hold", int'(duty), last_duty);
    en = 1'b1;
    have_rise = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) pwm_seg(80, 176, 1'b0, 1'b1);

    // Reset pulse while high discards the partial period.
    drive_rise();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_outputs("midreset");
    have_rise = 1'b0;
    repeat (44) @(negedge clk);
    pwm_in = 1'b0;
    repeat (192) @(negedge clk);
    for (int i = 0; i < 3; i++) pwm_seg(64, 192, 1'b1, 1'b0);

    // Randomized periods and directions.
    for (int i = 0; i < 20; i++)
      pwm_seg(int'($urandom_range(299, 3)), int'($urandom_range(299, 8)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    pwm_seg(64, 192, 1'b1, 1'b0);
    pwm_seg(64, 192, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 300, meaning the cycles without an expected edge before a timeout measurement is emitted (range 257..511).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have port en, input, 1, the decode enable.
REQ-005 SHALL have port pwm_in, input, 1, the asynchronous PWM line (nominal period 256 clk).
REQ-006 SHALL have ports dirp and dirn, input, 1 each, the asynchronous direction lines.
REQ-007 SHALL have port valid, output, 1, a one-cycle pulse on each new measurement.
REQ-008 SHALL have port duty, output, 8, the measured high-cycle count (0..255).
REQ-009 SHALL have port period, output, 9, the rise-to-rise cycle count; 0 on timeout.
REQ-010 SHALL have port speed, output, 9, the signed two's-complement speed.
REQ-011 SHALL have port timeout, output, 1, set when the current measurement came from a timeout.
REQ-012 SHALL have port dir_err, output, 1, set when dirp and dirn were equal at emission.

Function
REQ-013 SHALL pass pwm_in, dirp and dirn each through a 2-flop synchronizer; edge detection SHALL use the synchronized pwm level against its 1-cycle delayed copy.
REQ-014 SHALL implement the FSM states WAIT_RISE, HIGH, LOW and WAIT_FALL, with WAIT_RISE as the reset state.
REQ-015 WAIT_RISE: on a rise SHALL go to HIGH with hi_cnt=1 and per_cnt=1, and SHALL NOT emit (period incomplete).
REQ-016 HIGH: SHALL increment hi_cnt and per_cnt each cycle; on a fall SHALL go to LOW.
REQ-017 LOW: SHALL increment per_cnt; on a rise SHALL emit a measurement, then go to HIGH with hi_cnt=1 and per_cnt=1.
REQ-018 WAIT_FALL: on a fall SHALL go to WAIT_RISE.
REQ-019 Timeout: a 9-bit idle counter SHALL clear on every synchronized edge and on state entry; on reaching TIMEOUT it SHALL emit with timeout=1 and period=0.
REQ-020 Timeout duty SHALL be 0 if the line is low (next state WAIT_RISE) and 255 if the line is high (next state WAIT_FALL); the idle counter SHALL restart, so a constant line re-emits every TIMEOUT cycles.
REQ-021 hi_cnt SHALL saturate at 255 and per_cnt SHALL saturate at 511; no wrap-around.
REQ-022 Emit SHALL register duty, period, timeout and dir_err, compute speed, and pulse valid for exactly 1 cycle.
REQ-023 speed SHALL be {1'b0,duty} when dirp=1 and dirn=0, and SHALL be the 9-bit two's complement of {1'b0,duty} when dirp=0 and dirn=1.
REQ-024 When dirp equals dirn, the block SHALL set dir_err=1 and speed=0.
REQ-025 Latency SHALL be valid asserting exactly 3 clk cycles after the first clk edge that samples pwm_in high.
REQ-026 A rise and a timeout in the same cycle SHALL be resolved as the rise; the timeout is suppressed.
REQ-027 Between emissions, all outputs other than valid SHALL hold their last values.
REQ-028 en=0 SHALL force WAIT_RISE, clear hi_cnt, per_cnt and the idle counter, and hold valid=0; other outputs SHALL hold.
REQ-029 On en rising, the block SHALL NOT emit until a full rise-to-rise period or a timeout has occurred.

Reset
REQ-030 rst_n=0 at a clk edge SHALL clear the synchronizers, all counters, the FSM (to WAIT_RISE) and every output (valid, duty, period, speed, timeout, dir_err all 0).
REQ-031 Reset asserted mid-period SHALL discard the partial measurement; the first emission after release SHALL require a new complete period or a timeout.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the PWM_PERIOD=256 constant and the 8-bit duty and 9-bit speed widths.
REQ-033 The 2-flop synchronizer SHALL be the one sub-module, sync2, instantiated three times.

Verification
REQ-034 Bench: 64 high per 256, dirp=1 -> valid at each rise after the first with duty=64, period=256, speed=9'h040, timeout=0.
REQ-035 Bench: 100 high per 256, dirn=1 -> duty=100, speed=9'h19C, dir_err=0.
REQ-036 Bench: pwm_in held low for 700 cycles -> valid at cycles 300 and 600 with duty=0, period=0, speed=0, timeout=1.
REQ-037 Bench: pwm_in held high for 700 cycles after a rise -> timeout emits with duty=255 and timeout=1; the following low-high pattern resumes normal measurement after one complete period.
REQ-038 Bench: dirp=dirn=1 with a 50-cycle duty -> duty=50, speed=0, dir_err=1.
REQ-039 Bench: rst_n pulsed low for 1 cycle while in HIGH -> all outputs 0 the next cycle, with no valid until a full new period.
